memory_stage: RTL and testbench

- MEM-to-WB pipeline boundary of the 16-bit pipelined core.
- Selects the data word for write-back: store-path operand (thirdArg) or memory load data (loadData).
- Registers that word together with the WB-relevant control, PC+2, ALU result and destination register index.
- Single clock; one-cycle latency; synchronous active-high reset clears every output.

---
 rtl/core_pkg.sv | 17 +
 rtl/pipe_reg.sv | 21 ++
 rtl/memory_stage.sv | 63 ++++++
 tb/tb_memory_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: datapath widths and the RegStore write-back
// source encoding used by decode, the MEM/WB boundary and write-back.
package core_pkg;

  localparam int DATA_W  = 16;
  localparam int RD_W    = 3;
  localparam int STORE_W = 2;

  // Write-back source select carried on RegStore.
  typedef enum logic [STORE_W-1:0] {
    REG_STORE_ALU = 2'b00,
    REG_STORE_MEM = 2'b01,
    REG_STORE_PC2 = 2'b10,
    REG_STORE_IMM = 2'b11
  } reg_store_e;

endpackage

// File: rtl/pipe_reg.sv
// Parameterised pipeline register with synchronous active-high reset to 0.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high clear
//   d     - next value, captured every edge
//   q     - registered value
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= d;
  end

endmodule

// File: rtl/memory_stage.sv
// MEM-to-WB pipeline boundary of the 16-bit core. Selects the write-back
// data word (store-path operand or load data) and registers it together with
// the WB control, PC+2, ALU result and destination register index.
// Ports:
//   clk, reset              - clock and synchronous active-high reset
//   IRegWrite, IRegStore    - WB control from MEM
//   MemWrite, MemRead       - data-memory strobes (used by the memory macro only)
//   IPCP2, IALUResult       - PC+2 and ALU result of the instruction in MEM
//   thirdArg, loadData      - candidate write-back words
//   DataInSelect            - 1 selects thirdArg, 0 selects loadData
//   rdMem                   - destination register index
//   ORegWrite .. rdWB       - registered copies, one-cycle latency
module memory_stage
  import core_pkg::*;
#(
  parameter int DATA_W  = core_pkg::DATA_W,
  parameter int RD_W    = core_pkg::RD_W,
  parameter int STORE_W = core_pkg::STORE_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               IRegWrite,
  input  logic [STORE_W-1:0] IRegStore,
  input  logic               MemWrite,
  input  logic               MemRead,
  input  logic [DATA_W-1:0]  IPCP2,
  input  logic [DATA_W-1:0]  IALUResult,
  input  logic [DATA_W-1:0]  thirdArg,
  input  logic [RD_W-1:0]    rdMem,
  input  logic [DATA_W-1:0]  loadData,
  input  logic               DataInSelect,
  output logic               ORegWrite,
  output logic [STORE_W-1:0] ORegStore,
  output logic [DATA_W-1:0]  OPCP2,
  output logic [DATA_W-1:0]  OALUResult,
  output logic [DATA_W-1:0]  StoreMem,
  output logic [RD_W-1:0]    rdWB
);

  localparam int BUNDLE_W = 1 + STORE_W + 3 * DATA_W + RD_W;

  logic [DATA_W-1:0]   store_sel;
  logic [BUNDLE_W-1:0] bundle_d;
  logic [BUNDLE_W-1:0] bundle_q;

  // The strobes drive the memory macro directly; nothing here depends on them.
  logic unused_strobes;
  assign unused_strobes = MemWrite ^ MemRead;

  assign store_sel = DataInSelect ? thirdArg : loadData;

  assign bundle_d = {IRegWrite, IRegStore, IPCP2, IALUResult, store_sel, rdMem};

  pipe_reg #(.W(BUNDLE_W)) u_wb_reg (
    .clk   (clk),
    .reset (reset),
    .d     (bundle_d),
    .q     (bundle_q)
  );

  assign {ORegWrite, ORegStore, OPCP2, OALUResult, StoreMem, rdWB} = bundle_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  localparam int OW = 1 + 2 + 16 + 16 + 16 + 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        IRegWrite;
  logic [1:0]  IRegStore;
  logic        MemWrite;
  logic        MemRead;
  logic [15:0] IPCP2;
  logic [15:0] IALUResult;
  logic [15:0] thirdArg;
  logic [2:0]  rdMem;
  logic [15:0] loadData;
  logic        DataInSelect;
  logic        ORegWrite;
  logic [1:0]  ORegStore;
  logic [15:0] OPCP2;
  logic [15:0] OALUResult;
  logic [15:0] StoreMem;
  logic [2:0]  rdWB;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  memory_stage dut (
    .clk          (clk),
    .reset        (reset),
    .IRegWrite    (IRegWrite),
    .IRegStore    (IRegStore),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .IPCP2        (IPCP2),
    .IALUResult   (IALUResult),
    .thirdArg     (thirdArg),
    .rdMem        (rdMem),
    .loadData     (loadData),
    .DataInSelect (DataInSelect),
    .ORegWrite    (ORegWrite),
    .ORegStore    (ORegStore),
    .OPCP2        (OPCP2),
    .OALUResult   (OALUResult),
    .StoreMem     (StoreMem),
    .rdWB         (rdWB)
  );

  wire [OW-1:0] obs = {ORegWrite, ORegStore, OPCP2, OALUResult, StoreMem, rdWB};

  // Reference: what the WB registers must hold after an edge with these inputs.
  typedef struct packed {
    logic        we;
    logic [1:0]  st;
    logic [15:0] pc2;
    logic [15:0] alu;
    logic [15:0] data;
    logic [2:0]  rd;
  } wb_t;

  function automatic wb_t model_edge();
    wb_t r;
    r = '0;
    if (reset !== 1'b1) begin
      r.we   = IRegWrite;
      r.st   = IRegStore;
      r.pc2  = IPCP2;
      r.alu  = IALUResult;
      r.data = (DataInSelect === 1'b1) ? thirdArg : loadData;
      r.rd   = rdMem;
    end
    return r;
  endfunction

  task automatic set_scenario1();
    IRegWrite = 1'b1; IRegStore = 2'd1; MemRead = 1'b1; MemWrite = 1'b0;
    IALUResult = 16'h0004; thirdArg = 16'hAAAA; rdMem = 3'b101;
    IPCP2 = 16'h0011; loadData = 16'h0011; DataInSelect = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    set_scenario1();
    @(negedge clk);
    tests_run++;
    if (obs !== {OW{1'b0}}) begin
      tests_failed++;
      $display("FAIL reset: got %h expected %h", obs, {OW{1'b0}});
    end
  endtask

  task automatic test_store_path();
    wb_t e;
    reset = 1'b0;
    set_scenario1();
    MemWrite = 1'b1;
    e = '{we:1'b1, st:2'd1, pc2:16'h0011, alu:16'h0004, data:16'hAAAA, rd:3'b101};
    @(negedge clk);
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL store_path: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_load_path();
    wb_t e;
    DataInSelect = 1'b0;
    loadData = 16'h0011;
    e = '{we:1'b1, st:2'd1, pc2:16'h0011, alu:16'h0004, data:16'h0011, rd:3'b101};
    @(negedge clk);
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL load_path: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_latency();
    wb_t hold;
    wb_t e;
    hold = obs;
    IRegWrite = 1'b0; IRegStore = 2'd2; IPCP2 = 16'h1234; IALUResult = 16'h5678;
    thirdArg = 16'h0F0F; loadData = 16'hBEEF; DataInSelect = 1'b0; rdMem = 3'b010;
    e = model_edge();
    #3;
    tests_run++;
    if (obs !== hold) begin
      tests_failed++;
      $display("FAIL latency_hold: got %h expected %h", obs, hold);
    end
    @(posedge clk);
    #1;
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL latency_capture: got %h expected %h", obs, e);
    end
    tests_run++;
    if (StoreMem !== 16'hBEEF || OPCP2 !== 16'h1234) begin
      tests_failed++;
      $display("FAIL latency_fields: got StoreMem=%h OPCP2=%h expected BEEF 1234", StoreMem, OPCP2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream();
    wb_t e;
    reset = 1'b0;
    set_scenario1();
    @(negedge clk);
    tests_run++;
    if (obs === {OW{1'b0}}) begin
      tests_failed++;
      $display("FAIL mid_reset_setup: got %h expected nonzero", obs);
    end
    reset = 1'b1;
    IPCP2 = 16'hFFFF; thirdArg = 16'hFFFF;
    @(negedge clk);
    tests_run++;
    if (obs !== {OW{1'b0}}) begin
      tests_failed++;
      $display("FAIL mid_reset_clear: got %h expected %h", obs, {OW{1'b0}});
    end
    reset = 1'b0;
    IRegStore = 2'd3; rdMem = 3'b111; DataInSelect = 1'b1;
    e = model_edge();
    @(negedge clk);
    tests_run++;
    if (obs !== e) begin
      tests_failed++;
      $display("FAIL mid_reset_release: got %h expected %h", obs, e);
    end
  endtask

  task automatic test_strobes();
    wb_t e;
    reset = 1'b0;
    IRegWrite = 1'b1; IRegStore = 2'd2; IPCP2 = 16'hC0DE; IALUResult = 16'h8001;
    thirdArg = 16'h7E57; loadData = 16'h1DEA; DataInSelect = 1'b1; rdMem = 3'b011;
    e = '{we:1'b1, st:2'd2, pc2:16'hC0DE, alu:16'h8001, data:16'h7E57, rd:3'b011};
    for (int k = 0; k < 4; k++) begin
      MemRead  = k[0];
      MemWrite = k[1];
      @(negedge clk);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL strobes_%0d: got %h expected %h", k, obs, e);
      end
    end
  endtask

  task automatic test_random();
    wb_t e;
    for (int n = 0; n < 300; n++) begin
      reset        = ($urandom_range(0, 15) == 0);
      IRegWrite    = 1'($urandom);
      IRegStore    = 2'($urandom);
      MemWrite     = 1'($urandom);
      MemRead      = 1'($urandom);
      IPCP2        = 16'($urandom);
      IALUResult   = 16'($urandom);
      thirdArg     = 16'($urandom);
      loadData     = 16'($urandom);
      rdMem        = 3'($urandom);
      DataInSelect = 1'($urandom);
      e = model_edge();
      @(negedge clk);
      tests_run++;
      if (obs !== e) begin
        tests_failed++;
        $display("FAIL random_%0d: got %h expected %h", n, obs, e);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    set_scenario1();
    test_reset();
    test_store_path();
    test_load_path();
    test_latency();
    test_reset_mid_stream();
    test_strobes();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
